addr_sequencer: RTL and testbench

ADDR_SEQUENCER -- requirements
Module: addr_sequencer

---
 rtl/ntt_pkg.sv | 14 +
 rtl/addr_sequencer.sv | 114 +++++++++++
 tb/tb_addr_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared types and default sizing for the NTT address sequencing blocks.
package ntt_pkg;

  localparam int unsigned DefaultDepth = 85;
  localparam int unsigned DefaultPassW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRun,
    StDone
  } seq_state_e;

endpackage

// File: rtl/addr_sequencer.sv
// Sequences a companion address generator through one or more DEPTH-step passes,
// flagging consumed addresses (valid), pass ends (last) and completion (done).
module addr_sequencer
  import ntt_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned PASS_W = DefaultPassW
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     mode_in,
  input  logic [PASS_W-1:0]        npasses,
  input  logic                     stall,
  input  logic                     abort,
  output logic                     ag_reset,
  output logic                     ag_mode,
  output logic                     ag_incr,
  output logic                     valid,
  output logic                     last,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step
);

  localparam int unsigned StepW = $clog2(DEPTH);
  localparam logic [StepW-1:0] StepMax = StepW'(DEPTH - 1);

  seq_state_e        state_q, state_d;
  logic [StepW-1:0]  step_q, step_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              mode_q, mode_d;
  logic [PASS_W-1:0] npasses_q, npasses_d;
  logic [PASS_W-1:0] pass_final;

  // A requested pass count of zero runs a single pass.
  assign pass_final = (npasses_q == '0) ? '0 : npasses_q - PASS_W'(1);

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pass_d    = pass_q;
    mode_d    = mode_q;
    npasses_d = npasses_q;
    ag_reset  = 1'b0;
    valid     = 1'b0;
    last      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = mode_in;
          npasses_d = npasses;
          step_d    = '0;
          pass_d    = '0;
          state_d   = StInit;
        end
      end
      StInit: begin
        ag_reset = 1'b1;
        state_d  = abort ? StIdle : StRun;
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          valid = !stall;
          if (valid) begin
            last = (step_q == StepMax);
            if (last) begin
              step_d = '0;
              if (pass_q == pass_final) begin
                state_d = StDone;
              end else begin
                pass_d = pass_q + PASS_W'(1);
              end
            end else begin
              step_d = step_q + StepW'(1);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      step_q    <= '0;
      pass_q    <= '0;
      mode_q    <= 1'b0;
      npasses_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      pass_q    <= pass_d;
      mode_q    <= mode_d;
      npasses_q <= npasses_d;
    end
  end

  assign ag_incr = valid;
  assign ag_mode = mode_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign step    = step_q;

endmodule

// File: tb/tb_addr_sequencer.sv
// Scoreboard bench for addr_sequencer: directed runs push expected beats, a monitor checks them.
module tb_addr_sequencer;

  localparam int unsigned Depth = 85;
  localparam int unsigned PassW = 4;

  logic             clk = 1'b0;
  logic             reset_n, start, mode_in, stall, abort;
  logic [PassW-1:0] npasses;
  logic             ag_reset, ag_mode, ag_incr, valid, last, busy, done;
  logic [6:0]       step;

  // Entry layout: {is_done, mode, last, step}
  logic [9:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int init_total = 0;
  int valid_total = 0;
  int done_total = 0;
  int done_cyc = 0;
  int first_valid_cyc = 0;
  logic armed = 1'b0;

  addr_sequencer #(
    .DEPTH (Depth),
    .PASS_W(PassW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mode_in (mode_in),
    .npasses (npasses),
    .stall   (stall),
    .abort   (abort),
    .ag_reset(ag_reset),
    .ag_mode (ag_mode),
    .ag_incr (ag_incr),
    .valid   (valid),
    .last    (last),
    .busy    (busy),
    .done    (done),
    .step    (step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push_run(input logic m, input int np);
    int eff;
    eff = (np == 0) ? 1 : np;
    for (int p = 0; p < eff; p++) begin
      for (int s = 0; s < int'(Depth); s++) begin
        exp_q.push_back({1'b0, m, (s == int'(Depth) - 1), 7'(s)});
      end
    end
    exp_q.push_back({1'b1, m, 1'b0, 7'd0});
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepts start.
  task automatic start_seq(input logic m, input logic [PassW-1:0] np, output int sc);
    mode_in = m;
    npasses = np;
    start   = 1'b1;
    sc      = cyc;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mode_in = ~m;
    npasses = '0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_total == d0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_total == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, expected one", budget);
    end
  endtask

  task automatic wait_step(input logic [6:0] target);
    int n;
    n = 0;
    while (step != target && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_step", step, target);
  endtask

  // Monitor: pops the scoreboard on every valid beat and every done pulse.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset_n === 1'b1) begin
      check("incr_last_qual", {ag_incr, last & ~valid}, {valid, 1'b0});
      if (ag_reset) begin
        init_total++;
        armed = 1'b1;
      end
      if (valid) begin
        valid_total++;
        if (armed) begin
          first_valid_cyc = cyc;
          armed = 1'b0;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got beat at step %0d, expected none", step);
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", {1'b0, ag_mode, last, step}, e);
        end
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("sb_done", {done, ag_mode, last, step}, e);
        end
      end
    end
  end

  initial begin
    int sc, d0, i0, v0;
    reset_n = 1'b0;
    start   = 1'b0;
    mode_in = 1'b0;
    npasses = '0;
    stall   = 1'b0;
    abort   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ag_reset, ag_mode, ag_incr, valid, last, busy, done, step}, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", {busy, done, ag_reset}, 0);

    // Linear single pass
    d0 = done_total; i0 = init_total; v0 = valid_total;
    push_run(1'b0, 1);
    start_seq(1'b0, 4'd1, sc);
    check("init_ag_reset", {ag_reset, ag_incr, valid, busy}, 4'b1001);
    wait_done(d0, 200);
    check("first_valid_latency", first_valid_cyc - sc, 2);
    check("done_cycle_1pass", done_cyc - sc, 87);
    check("valid_count_1pass", valid_total - v0, 85);
    check("init_count_1pass", init_total - i0, 1);
    check("idle_after_done", busy, 0);

    // Bank-rotate, three passes
    d0 = done_total; i0 = init_total; v0 = valid_total;
    push_run(1'b1, 3);
    start_seq(1'b1, 4'd3, sc);
    wait_done(d0, 400);
    check("done_cycle_3pass", done_cyc - sc, 257);
    check("valid_count_3pass", valid_total - v0, 255);
    check("init_count_3pass", init_total - i0, 1);
    check("done_count_3pass", done_total - d0, 1);

    // Stall during cycles 10..14 after start
    d0 = done_total; v0 = valid_total;
    push_run(1'b0, 1);
    start_seq(1'b0, 4'd1, sc);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    stall = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("stall_no_valid", {valid, ag_incr}, 0);
      check("stall_step_frozen", step, 8);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    wait_done(d0, 200);
    check("done_cycle_stall", done_cyc - sc, 92);
    check("valid_count_stall", valid_total - v0, 85);

    // Abort at step 40, then a full rerun
    d0 = done_total;
    for (int s = 0; s < 40; s++) exp_q.push_back({1'b0, 1'b0, 1'b0, 7'(s)});
    start_seq(1'b0, 4'd1, sc);
    wait_step(7'd40);
    abort = 1'b1;
    #1;
    check("abort_cycle_outputs", {valid, ag_incr, busy}, 3'b001);
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_to_idle", {busy, done}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_total - d0, 0);
    check("abort_queue_drained", exp_q.size(), 0);
    push_run(1'b0, 1);
    start_seq(1'b0, 4'd1, sc);
    wait_done(d0, 200);
    check("done_cycle_rerun", done_cyc - sc, 87);

    // Asynchronous reset at step 20, then start with npasses=0 together with abort
    for (int s = 0; s < 20; s++) exp_q.push_back({1'b0, 1'b1, 1'b0, 7'(s)});
    start_seq(1'b1, 4'd2, sc);
    wait_step(7'd20);
    reset_n = 1'b0;
    start   = 1'b1;
    #1;
    check("async_reset_outputs", {ag_reset, ag_mode, ag_incr, valid, last, busy, done, step}, 0);
    check("reset_queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    start   = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("no_pending_after_reset", busy, 0);
    d0 = done_total; v0 = valid_total;
    push_run(1'b0, 0);
    abort = 1'b1;
    start_seq(1'b0, 4'd0, sc);
    abort = 1'b0;
    check("start_with_abort_accepted", {busy, ag_reset}, 2'b11);
    wait_done(d0, 200);
    check("done_cycle_np0", done_cyc - sc, 87);
    check("valid_count_np0", valid_total - v0, 85);

    // Start held high across the whole run
    d0 = done_total; i0 = init_total;
    push_run(1'b1, 1);
    push_run(1'b1, 1);
    mode_in = 1'b1;
    npasses = 4'd1;
    start   = 1'b1;
    sc      = cyc;
    wait_done(d0, 200);
    check("held_start_done_cycle", done_cyc - sc, 87);
    check("held_start_idle", busy, 0);
    check("held_start_one_init", init_total - i0, 1);
    @(posedge clk);
    #1;
    check("held_start_reinit", {ag_reset, busy}, 2'b11);
    start = 1'b0;
    wait_done(d0 + 1, 200);
    check("held_start_second_done", done_cyc - sc, 175);
    check("held_start_two_inits", init_total - i0, 2);
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
